// File: rtl/wm_pkg.sv
// Shared definitions for the wash-cycle sequencer: phase encoding and the
// actuator decode used by wm_cycle_ctrl.
package wm_pkg;

  // Phase encoding; the numeric values are exported on o_phase to the display
  // and buzzer blocks, so they must stay fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_AGIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } wm_state_e;

  typedef struct packed {
    logic valve;
    logic motor;
    logic drain;
  } wm_act_t;

  // Actuators follow the phase, and are all forced off while paused.
  function automatic wm_act_t wm_decode_act(input wm_state_e st, input logic paused);
    wm_act_t a;
    a = '0;
    if (!paused) begin
      case (st)
        ST_FILL:  a.valve = 1'b1;
        ST_AGIT:  a.motor = 1'b1;
        ST_DRAIN: a.drain = 1'b1;
        ST_SPIN: begin
          a.motor = 1'b1;
          a.drain = 1'b1;
        end
        default: a = '0;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, pulses tick_o
// on the last count, and restarts from 0 on clear (clear wins over enable).
module wm_tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear, hold when disabled, wrap at the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/wm_cycle_ctrl.sv
// Wash-program sequencer: fill -> agitate -> drain passes (wash plus
// mode-dependent rinses), then spin and done, with pause on the start button.
// Optional fill-timeout fault enabled by defining WM_FILL_TIMEOUT_EN.
module wm_cycle_ctrl
  import wm_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned RINSE_MAX = 3,
  parameter int unsigned TIME_W    = 8,
  parameter int unsigned WASH_T    = 10,
  parameter int unsigned MODE_STEP = 5,
  parameter int unsigned RINSE_T   = 6,
  parameter int unsigned DRAIN_T   = 4,
  parameter int unsigned SPIN_T    = 8,
  parameter int unsigned DONE_T    = 3,
  parameter int unsigned FILL_TMO  = 20,
  localparam int unsigned MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start_n,
  input  logic              i_water_full_n,
  input  logic [MW-1:0]     i_mode,
  output logic [2:0]        o_phase,
  output logic [TIME_W-1:0] o_remain,
  output logic [1:0]        o_pass,
  output logic              o_valve,
  output logic              o_motor,
  output logic              o_drain,
  output logic              o_busy,
  output logic              o_paused,
  output logic              o_done,
  output logic              o_fault
);

`ifdef WM_FILL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [TIME_W-1:0] RINSE_LD = TIME_W'(RINSE_T);
  localparam logic [TIME_W-1:0] DRAIN_LD = TIME_W'(DRAIN_T);
  localparam logic [TIME_W-1:0] SPIN_LD  = TIME_W'(SPIN_T);
  localparam logic [TIME_W-1:0] DONE_LD  = TIME_W'(DONE_T);
  // Without the timeout FILL is untimed and shows 0 remaining.
  localparam logic [TIME_W-1:0] FILL_LD  = TMO_EN ? TIME_W'(FILL_TMO) : '0;

  // Rinse passes for a mode: min(mode+1, RINSE_MAX).
  function automatic logic [1:0] rinse_cnt(input logic [MW-1:0] m);
    int unsigned r;
    r = 32'(m) + 32'd1;
    if (r > RINSE_MAX) r = RINSE_MAX;
    return 2'(r);
  endfunction

  wm_state_e         state_q, state_d;
  logic [TIME_W-1:0] remain_q, remain_d;
  logic [1:0]        pass_q, pass_d;
  logic [1:0]        rinses_q, rinses_d;
  logic [MW-1:0]     mode_q, mode_d;
  logic              paused_q, paused_d;
  logic [2:0]        start_sync_q;
  logic [1:0]        wfull_sync_q;

  logic              press;
  logic              water_full;
  logic              tick;
  logic              tick_en;
  logic              tick_clr;
  logic              timed;
  logic [TIME_W:0]   wash_sum;
  logic [TIME_W-1:0] wash_ld;
  wm_act_t           act;

  // Stage 3 of the start chain only remembers the previous synchronised level
  // so a press is a single-cycle falling edge.
  assign press      = start_sync_q[2] & ~start_sync_q[1];
  assign water_full = ~wfull_sync_q[1];

  // Wash time computed one bit wider so an oversize mode saturates.
  assign wash_sum = (TIME_W+1)'(WASH_T) + (TIME_W+1)'(32'(mode_q) * MODE_STEP);
  assign wash_ld  = wash_sum[TIME_W] ? '1 : wash_sum[TIME_W-1:0];

  assign timed    = (state_q inside {ST_AGIT, ST_DRAIN, ST_SPIN, ST_DONE}) ||
                    (TMO_EN && (state_q == ST_FILL));
  assign tick_en  = timed && !paused_q;
  assign tick_clr = (state_d != state_q);

  wm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tick_en),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Next-state: a press always takes priority over a tick in the same cycle,
  // and water-full takes priority over a fill timeout.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    pass_d   = pass_q;
    rinses_d = rinses_q;
    mode_d   = mode_q;
    paused_d = paused_q;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          mode_d   = i_mode;
          rinses_d = rinse_cnt(i_mode);
          pass_d   = '0;
          remain_d = FILL_LD;
          state_d  = ST_FILL;
        end
      end
      ST_FILL, ST_AGIT, ST_DRAIN, ST_SPIN: begin
        if (press) begin
          paused_d = ~paused_q;
        end else if (!paused_q) begin
          case (state_q)
            ST_FILL: begin
              if (water_full) begin
                state_d  = ST_AGIT;
                remain_d = (pass_q == '0) ? wash_ld : RINSE_LD;
              end else if (TMO_EN && tick) begin
                if (remain_q == '0) state_d = ST_FAULT;
                else remain_d = remain_q - TIME_W'(1);
              end
            end
            ST_AGIT: begin
              if (tick) begin
                if (remain_q == '0) begin
                  state_d  = ST_DRAIN;
                  remain_d = DRAIN_LD;
                end else begin
                  remain_d = remain_q - TIME_W'(1);
                end
              end
            end
            ST_DRAIN: begin
              if (tick) begin
                if (remain_q == '0) begin
                  if (pass_q < rinses_q) begin
                    pass_d   = pass_q + 2'd1;
                    state_d  = ST_FILL;
                    remain_d = FILL_LD;
                  end else begin
                    state_d  = ST_SPIN;
                    remain_d = SPIN_LD;
                  end
                end else begin
                  remain_d = remain_q - TIME_W'(1);
                end
              end
            end
            ST_SPIN: begin
              if (tick) begin
                if (remain_q == '0) begin
                  state_d  = ST_DONE;
                  remain_d = DONE_LD;
                end else begin
                  remain_d = remain_q - TIME_W'(1);
                end
              end
            end
            default: state_d = state_q;
          endcase
        end
      end
      ST_DONE: begin
        if (press || (tick && (remain_q == '0))) begin
          state_d  = ST_IDLE;
          remain_d = '0;
          pass_d   = '0;
        end else if (tick) begin
          remain_d = remain_q - TIME_W'(1);
        end
      end
      ST_FAULT: begin
        if (press) begin
          state_d  = ST_IDLE;
          remain_d = '0;
          pass_d   = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        remain_d = '0;
        pass_d   = '0;
        paused_d = 1'b0;
      end
    endcase
  end

  // State, counters and input synchronisers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remain_q     <= '0;
      pass_q       <= '0;
      rinses_q     <= '0;
      mode_q       <= '0;
      paused_q     <= 1'b0;
      start_sync_q <= '1;
      wfull_sync_q <= '1;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      pass_q       <= pass_d;
      rinses_q     <= rinses_d;
      mode_q       <= mode_d;
      paused_q     <= paused_d;
      start_sync_q <= {start_sync_q[1:0], i_start_n};
      wfull_sync_q <= {wfull_sync_q[0], i_water_full_n};
    end
  end

  assign act      = wm_decode_act(state_q, paused_q);
  assign o_valve  = act.valve;
  assign o_motor  = act.motor;
  assign o_drain  = act.drain;
  assign o_phase  = state_q;
  assign o_remain = remain_q;
  assign o_pass   = pass_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_paused = paused_q;
  assign o_done   = (state_q == ST_DONE);
  assign o_fault  = TMO_EN && (state_q == ST_FAULT);

endmodule
